frame_pixel_streamer: RTL and testbench

//  Frame-buffer reader that sources the raster pixel stream consumed by the filter blocks (edge detect, etc.).
//  On a start pulse it reads one full frame from a synchronous-read RAM (1-cycle latency) in raster order.
//  It emits the pixels with valid/ready handshake and frame/line markers. A small credit-controlled FIFO absorbs RAM latency under backpressure.

---
 rtl/frame_pixel_streamer_pkg.sv | 34 +++
 rtl/frame_pixel_streamer_tag_fifo.sv | 71 +++++++
 rtl/frame_pixel_streamer.sv | 192 +++++++++++++++++++
 tb/tb_frame_pixel_streamer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pixel_streamer_pkg.sv
// ----------------------------------------------------------------------------
// frame_stream_pkg
//   Shared types for the frame streaming blocks (reader and writer side).
//   - state_t      : frame reader FSM states
//   - pixel_tag_t  : raster position markers carried alongside each pixel
//   - TAG_BITS     : packed width of pixel_tag_t, for generic storage
//   - width_for()  : index width for a counter that spans 'count' values
// ----------------------------------------------------------------------------
package frame_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } pixel_tag_t;

    localparam int TAG_BITS = $bits(pixel_tag_t);

    // $clog2 of 1 is 0, which would give a zero-width counter; clamp to 1.
    function automatic int width_for(input int count);
        if (count <= 2) begin
            return 1;
        end
        return $clog2(count);
    endfunction

endpackage

// File: rtl/frame_pixel_streamer_tag_fifo.sv
// ----------------------------------------------------------------------------
// pixel_tag_fifo
//   Synchronous FIFO holding a pixel plus its tag bits. Head entry is
//   presented combinationally (first-word fall-through). Push and pop in the
//   same cycle are allowed, including when full.
// Ports
//   clk, reset           clock, synchronous active-high reset (flushes)
//   push, push_data,
//   push_tag             write side
//   pop                  read side; ignored when empty
//   head_data, head_tag  oldest entry
//   full, empty, count   occupancy status
// ----------------------------------------------------------------------------
module pixel_tag_fifo #(
    parameter  int DATA_BITS = 8,
    parameter  int TAG_BITS  = 3,
    parameter  int DEPTH     = 4,
    localparam int PTR_BITS  = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic [TAG_BITS-1:0]  push_tag,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] head_data,
    output logic [TAG_BITS-1:0]  head_tag,
    output logic                 full,
    output logic                 empty,
    output logic [PTR_BITS:0]    count
);

    logic [DATA_BITS+TAG_BITS-1:0] storage [DEPTH];
    logic [PTR_BITS:0]             wr_ptr;
    logic [PTR_BITS:0]             rd_ptr;
    logic                          do_push;
    logic                          do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        count   = wr_ptr - rd_ptr;
        full    = (count == (PTR_BITS+1)'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: an entry is only visible once pushed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr[PTR_BITS-1:0]] <= {push_data, push_tag};
        end
    end

    assign {head_data, head_tag} = storage[rd_ptr[PTR_BITS-1:0]];

endmodule

// File: rtl/frame_pixel_streamer.sv
// ----------------------------------------------------------------------------
// frame_pixel_streamer
//   Reads one frame from a synchronous-read RAM (1-cycle latency) in raster
//   order after a start pulse, and streams it out with valid/ready plus
//   sof/eol/eof markers. Reads are credit limited so the output FIFO can
//   always absorb the data already requested from the RAM.
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start             1-cycle pulse, accepted only when idle
//   busy              high whenever not idle
//   frame_done        1-cycle pulse after the eof pixel has transferred
//   mem_rd_en         RAM read strobe
//   mem_rd_addr       linear address y*IMG_WIDTH + x
//   mem_rd_data       RAM read data, valid one cycle after mem_rd_en
//   pixel_out         pixel data from FIFO head
//   pixel_out_valid   FIFO non-empty
//   pixel_out_ready   downstream accept
//   pixel_out_sof     first pixel of frame
//   pixel_out_eol     last pixel of line
//   pixel_out_eof     last pixel of frame
// ----------------------------------------------------------------------------
module frame_pixel_streamer
    import frame_stream_pkg::*;
#(
    parameter  int IMG_WIDTH  = 640,
    parameter  int IMG_HEIGHT = 480,
    parameter  int PIXEL_BITS = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int ADDR_BITS  = width_for(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  mem_rd_en,
    output logic [ADDR_BITS-1:0]  mem_rd_addr,
    input  logic [PIXEL_BITS-1:0] mem_rd_data,
    output logic [PIXEL_BITS-1:0] pixel_out,
    output logic                  pixel_out_valid,
    input  logic                  pixel_out_ready,
    output logic                  pixel_out_sof,
    output logic                  pixel_out_eol,
    output logic                  pixel_out_eof
);

    localparam int X_BITS   = width_for(IMG_WIDTH);
    localparam int Y_BITS   = width_for(IMG_HEIGHT);
    localparam int CNT_BITS = $clog2(FIFO_DEPTH) + 1;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [X_BITS-1:0]    X_LAST    = X_BITS'(IMG_WIDTH - 1);
    localparam logic [Y_BITS-1:0]    Y_LAST    = Y_BITS'(IMG_HEIGHT - 1);
    localparam logic [CNT_BITS-1:0]  CREDITS   = CNT_BITS'(FIFO_DEPTH);

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_BITS-1:0]    addr;
    logic [X_BITS-1:0]       x;
    logic [Y_BITS-1:0]       y;
    logic                    inflight;
    pixel_tag_t              issue_tag;
    pixel_tag_t              tag_d;
    pixel_tag_t              head_tag;
    logic [TAG_BITS-1:0]     head_tag_bits;
    logic [PIXEL_BITS-1:0]   head_data;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_BITS-1:0]     fifo_count;
    logic [CNT_BITS-1:0]     used;

    // A read is only issued when the FIFO has room for it even after the
    // read already in flight lands. This is what makes overflow impossible
    // without ever looking at downstream ready.
    always_comb begin
        used      = fifo_count + CNT_BITS'(inflight);
        mem_rd_en = (state == STREAM) && (used < CREDITS);
        push      = inflight;
        pop       = !fifo_empty && pixel_out_ready;

        issue_tag.sof = (x == '0) && (y == '0);
        issue_tag.eol = (x == X_LAST);
        issue_tag.eof = (x == X_LAST) && (y == Y_LAST);
    end

    // Frame sequencing. STREAM ends as soon as the last address is issued;
    // DRAIN then waits for the eof pixel to leave the FIFO.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (mem_rd_en && (addr == LAST_ADDR)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_tag.eof) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counters are held at zero while idle so each frame starts at (0,0).
    // The linear address saturates at the last pixel; x/y advance in step.
    // The tag register follows the read by one cycle, lining up with the
    // RAM data it describes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addr     <= '0;
            x        <= '0;
            y        <= '0;
            inflight <= 1'b0;
            tag_d    <= '0;
        end else begin
            state    <= state_next;
            inflight <= mem_rd_en;
            tag_d    <= issue_tag;
            if (state == IDLE) begin
                addr <= '0;
                x    <= '0;
                y    <= '0;
            end else if (mem_rd_en) begin
                if (addr != LAST_ADDR) begin
                    addr <= addr + 1'b1;
                end
                if (x == X_LAST) begin
                    x <= '0;
                    if (y != Y_LAST) begin
                        y <= y + 1'b1;
                    end
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    // The credit scheme must never let a push hit a full FIFO unpopped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && fifo_full && !pop));
        end
    end

    pixel_tag_fifo #(
        .DATA_BITS (PIXEL_BITS),
        .TAG_BITS  (TAG_BITS),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (mem_rd_data),
        .push_tag  (tag_d),
        .pop       (pop),
        .head_data (head_data),
        .head_tag  (head_tag_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Outputs are forced to zero when nothing is valid so that the stream
    // is clean after reset, when FIFO storage is still uninitialised.
    always_comb begin
        head_tag        = pixel_tag_t'(head_tag_bits);
        busy            = (state != IDLE);
        frame_done      = (state == DONE);
        mem_rd_addr     = addr;
        pixel_out_valid = !fifo_empty;
        pixel_out       = fifo_empty ? '0 : head_data;
        pixel_out_sof   = !fifo_empty && head_tag.sof;
        pixel_out_eol   = !fifo_empty && head_tag.eol;
        pixel_out_eof   = !fifo_empty && head_tag.eof;
    end

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// ----------------------------------------------------------------------------
// tb_frame_pixel_streamer
//   Directed bench for frame_pixel_streamer at 4x3 pixels. The RAM model
//   returns addr+16. Expected pixels are queued when a frame is started and
//   popped by the transfer monitor.
// ----------------------------------------------------------------------------
module tb_frame_pixel_streamer;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       eof;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pixel_out_ready = 1'b0;
    logic       busy;
    logic       frame_done;
    logic       mem_rd_en;
    logic [3:0] mem_rd_addr;
    logic [7:0] mem_rd_data = 8'd0;
    logic [7:0] pixel_out;
    logic       pixel_out_valid;
    logic       pixel_out_sof;
    logic       pixel_out_eol;
    logic       pixel_out_eof;

    int   vectors = 0;
    int   miscompares = 0;
    int   doneCount = 0;
    int   eofCount = 0;
    exp_t sb[$];
    exp_t monExp;

    frame_pixel_streamer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .PIXEL_BITS (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .busy            (busy),
        .frame_done      (frame_done),
        .mem_rd_en       (mem_rd_en),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_data     (mem_rd_data),
        .pixel_out       (pixel_out),
        .pixel_out_valid (pixel_out_valid),
        .pixel_out_ready (pixel_out_ready),
        .pixel_out_sof   (pixel_out_sof),
        .pixel_out_eol   (pixel_out_eol),
        .pixel_out_eof   (pixel_out_eof)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM preloaded with mem[a] = a + 16.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= {4'b0000, mem_rd_addr} + 8'd16;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge and drive that cycle's inputs.
    task automatic applyStimulus(input logic st, input logic rdy);
        @(posedge clk);
        #1;
        start = st;
        pixel_out_ready = rdy;
    endtask

    task automatic pushFrame();
        exp_t e;
        for (int a = 0; a < N; a++) begin
            e.data = 8'(a + 16);
            e.sof  = (a == 0);
            e.eol  = ((a % W) == W - 1);
            e.eof  = (a == N - 1);
            sb.push_back(e);
        end
    endtask

    // Transfer monitor: every accepted pixel must match the next queued one.
    always @(negedge clk) begin
        if (frame_done) begin
            doneCount++;
        end
        if (!reset && pixel_out_valid && pixel_out_ready) begin
            if (pixel_out_eof) begin
                eofCount++;
            end
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                monExp = sb.pop_front();
                checkOutput("px_data", 32'(pixel_out), 32'(monExp.data));
                checkOutput("px_sof", 32'(pixel_out_sof), 32'(monExp.sof));
                checkOutput("px_eol", 32'(pixel_out_eol), 32'(monExp.eol));
                checkOutput("px_eof", 32'(pixel_out_eof), 32'(monExp.eof));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        int e0;
        int rdCount;
        logic seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(frame_done), 32'd0);
        checkOutput("rst_rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("rst_addr", 32'(mem_rd_addr), 32'd0);
        checkOutput("rst_valid", 32'(pixel_out_valid), 32'd0);
        checkOutput("rst_pixel", 32'(pixel_out), 32'd0);
        checkOutput("rst_sof", 32'(pixel_out_sof), 32'd0);
        checkOutput("rst_eol", 32'(pixel_out_eol), 32'd0);
        checkOutput("rst_eof", 32'(pixel_out_eof), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1);

        // Scenario 1: full-rate frame with exact cycle timing
        $display("[TB] scenario 1: ready held high");
        pushFrame();
        d0 = doneCount;
        applyStimulus(1'b1, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b0, 1'b1);
            @(negedge clk);
            checkOutput("s1_valid", 32'(pixel_out_valid), 32'(k >= 3 && k <= 14));
            checkOutput("s1_done", 32'(frame_done), 32'(k == 15));
            checkOutput("s1_busy", 32'(busy), 32'(k <= 15));
        end
        checkOutput("s1_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("s1_done_count", 32'(doneCount - d0), 32'd1);

        // Scenario 2: backpressure from the start of the frame
        $display("[TB] scenario 2: backpressure");
        pushFrame();
        d0 = doneCount;
        rdCount = 0;
        applyStimulus(1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b0, 1'b0);
            @(negedge clk);
            if (mem_rd_en) begin
                rdCount++;
            end
            if (k >= 3) begin
                checkOutput("s2_valid_held", 32'(pixel_out_valid), 32'd1);
                checkOutput("s2_data_stable", 32'(pixel_out), 32'd16);
                checkOutput("s2_sof_stable", 32'(pixel_out_sof), 32'd1);
            end
        end
        checkOutput("s2_reads_stalled", 32'(rdCount), 32'd4);
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            applyStimulus(1'b0, 1'b1);
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
            end
        end
        checkOutput("s2_frame_done", 32'(seen), 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("s2_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("s2_done_count", 32'(doneCount - d0), 32'd1);

        // Scenario 3: random ready over three frames
        $display("[TB] scenario 3: random ready");
        d0 = doneCount;
        for (int f = 0; f < 3; f++) begin
            pushFrame();
            applyStimulus(1'b1, 1'($urandom_range(0, 1)));
            seen = 1'b0;
            for (int k = 0; k < 300 && !seen; k++) begin
                applyStimulus(1'b0, 1'($urandom_range(0, 1)));
                @(negedge clk);
                if (frame_done) begin
                    seen = 1'b1;
                end
            end
            checkOutput("s3_frame_done", 32'(seen), 32'd1);
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("s3_done_pulses", 32'(doneCount - d0), 32'd3);
        checkOutput("s3_sb_empty", 32'(sb.size()), 32'd0);

        // Scenario 4: start re-pulsed mid-frame is ignored
        $display("[TB] scenario 4: start while busy");
        pushFrame();
        d0 = doneCount;
        applyStimulus(1'b1, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'(k == 5), 1'b1);
            @(negedge clk);
            checkOutput("s4_valid", 32'(pixel_out_valid), 32'(k >= 3 && k <= 14));
            checkOutput("s4_done", 32'(frame_done), 32'(k == 15));
            checkOutput("s4_busy", 32'(busy), 32'(k <= 15));
        end
        checkOutput("s4_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("s4_done_count", 32'(doneCount - d0), 32'd1);

        // Scenario 5: reset in cycle 7 of a frame, then a clean frame
        $display("[TB] scenario 5: reset mid-frame");
        pushFrame();
        d0 = doneCount;
        applyStimulus(1'b1, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b0, 1'b1);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("s5_pixels_before_reset", 32'(sb.size()), 32'(N - 4));
        sb.delete();
        @(negedge clk);
        checkOutput("s5_busy", 32'(busy), 32'd0);
        checkOutput("s5_valid", 32'(pixel_out_valid), 32'd0);
        checkOutput("s5_done", 32'(frame_done), 32'd0);
        checkOutput("s5_rd_en", 32'(mem_rd_en), 32'd0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("s5_no_done", 32'(doneCount - d0), 32'd0);
        pushFrame();
        applyStimulus(1'b1, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            applyStimulus(1'b0, 1'b1);
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
            end
        end
        checkOutput("s5_frame_done", 32'(seen), 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("s5_sb_empty", 32'(sb.size()), 32'd0);

        // Scenario 6: ready toggling every cycle through eof
        $display("[TB] scenario 6: toggling ready");
        pushFrame();
        d0 = doneCount;
        e0 = eofCount;
        applyStimulus(1'b1, 1'b1);
        seen = 1'b0;
        for (int k = 1; k < 100 && !seen; k++) begin
            applyStimulus(1'b0, 1'(k % 2));
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
            end
        end
        checkOutput("s6_frame_done", 32'(seen), 32'd1);
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkOutput("s6_idle_after_done", 32'(busy), 32'd0);
        checkOutput("s6_done_one_cycle", 32'(frame_done), 32'd0);
        checkOutput("s6_eof_once", 32'(eofCount - e0), 32'd1);
        checkOutput("s6_done_count", 32'(doneCount - d0), 32'd1);
        checkOutput("s6_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
